// File: rtl/jtframe_sdram64_rdcache.sv
// Four-slot read cache in front of one SDRAM bank port.
// Each slot owns one 4x16-bit line; misses are fetched with round-robin.
module jtframe_sdram64_rdcache #(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [AW-1:0] slot0_addr,
    input  logic [AW-1:0] slot1_addr,
    input  logic [AW-1:0] slot2_addr,
    input  logic [AW-1:0] slot3_addr,
    input  logic [3:0]    slot_cs,
    output logic [3:0]    slot_ok,
    output logic [15:0]   slot0_dout,
    output logic [15:0]   slot1_dout,
    output logic [15:0]   slot2_dout,
    output logic [15:0]   slot3_dout,
    output logic [AW-1:0] ba_addr,
    output logic          ba_rd,
    input  logic          ba_ack,
    input  logic          ba_dst,
    input  logic          ba_dok,
    input  logic          ba_rdy,
    input  logic [15:0]   ba_din
);
    localparam int TW = AW - 2;

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    logic [AW-1:0] addr [4];
    logic [15:0]   line_q [4][4];
    logic [15:0]   line_d [4][4];
    logic [TW-1:0] tag_q [4];
    logic [TW-1:0] tag_d [4];
    logic [15:0]   dout_q [4];
    logic [15:0]   dout_d [4];
    logic [3:0]    valid_q, valid_d;
    logic [3:0]    ok_q, ok_d;
    logic [3:0]    hit, pend;
    state_t        st_q, st_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [TW-1:0] btag_q, btag_d;
    logic [AW-1:0] ba_addr_q, ba_addr_d;
    logic          ba_rd_q, ba_rd_d;
    logic          clrs_q, clrs_d;
    logic [1:0]    pick;
    logic          found;

    assign addr[0] = slot0_addr;
    assign addr[1] = slot1_addr;
    assign addr[2] = slot2_addr;
    assign addr[3] = slot3_addr;

    assign slot_ok    = ok_q;
    assign slot0_dout = dout_q[0];
    assign slot1_dout = dout_q[1];
    assign slot2_dout = dout_q[2];
    assign slot3_dout = dout_q[3];
    assign ba_addr    = ba_addr_q;
    assign ba_rd      = ba_rd_q;

    // Per-slot hit detection, registered ok and data word selection
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            hit[n]    = valid_q[n] && (tag_q[n] == addr[n][AW-1:2]);
            pend[n]   = slot_cs[n] & ~hit[n];
            ok_d[n]   = slot_cs[n] & hit[n] & ~clr;
            dout_d[n] = hit[n] ? line_q[n][addr[n][1:0]] : dout_q[n];
        end
    end

    // Round-robin search for the next pending slot, starting after last
    always_comb begin
        logic [1:0] idx;
        idx   = '0;
        pick  = last_q;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && pend[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Bank request FSM and line fill
    always_comb begin
        st_d      = st_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        btag_d    = btag_q;
        ba_addr_d = ba_addr_q;
        ba_rd_d   = ba_rd_q;
        clrs_d    = clrs_q | clr;
        line_d    = line_q;
        tag_d     = tag_q;
        valid_d   = clr ? 4'b0 : valid_q;
        unique case (st_q)
            IDLE: begin
                if (found) begin
                    gnt_d     = pick;
                    last_d    = pick;
                    ba_addr_d = {addr[pick][AW-1:2], 2'b00};
                    btag_d    = addr[pick][AW-1:2];
                    ba_rd_d   = 1'b1;
                    clrs_d    = clr;
                    // The old line gets overwritten word by word, so it
                    // must not be served while the fill is in progress.
                    valid_d[pick] = 1'b0;
                    st_d      = REQ;
                end
            end
            REQ: begin
                if (ba_ack) begin
                    ba_rd_d = 1'b0;
                    st_d    = DATA;
                end
            end
            DATA: begin
                if (ba_dst) begin
                    line_d[gnt_q][0] = ba_din;
                    cnt_d = 2'd1;
                end else if (ba_dok) begin
                    line_d[gnt_q][cnt_q] = ba_din;
                    cnt_d = cnt_q + 2'd1;
                end
                if (ba_rdy) begin
                    tag_d[gnt_q]   = btag_q;
                    valid_d[gnt_q] = ~(clrs_q | clr);
                    st_d           = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= IDLE;
            gnt_q     <= '0;
            last_q    <= 2'd3;
            cnt_q     <= '0;
            btag_q    <= '0;
            ba_addr_q <= '0;
            ba_rd_q   <= 1'b0;
            clrs_q    <= 1'b0;
            valid_q   <= '0;
            ok_q      <= '0;
            line_q    <= '{default: '0};
            tag_q     <= '{default: '0};
            dout_q    <= '{default: '0};
        end else begin
            st_q      <= st_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            btag_q    <= btag_d;
            ba_addr_q <= ba_addr_d;
            ba_rd_q   <= ba_rd_d;
            clrs_q    <= clrs_d;
            valid_q   <= valid_d;
            ok_q      <= ok_d;
            line_q    <= line_d;
            tag_q     <= tag_d;
            dout_q    <= dout_d;
        end
    end

endmodule

// File: tb/tb_jtframe_sdram64_rdcache.sv
// Bench for jtframe_sdram64_rdcache: memory-backed bank model,
// directed scenarios and a randomized phase checked against memory.
module tb_jtframe_sdram64_rdcache;
    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic [AW-1:0] a [4];
    logic [3:0]    cs = '0;
    logic [3:0]    ok;
    logic [15:0]   dout [4];
    logic [AW-1:0] ba_addr;
    logic          ba_rd;
    logic          ba_ack = 1'b0;
    logic          ba_dst = 1'b0;
    logic          ba_dok = 1'b0;
    logic          ba_rdy = 1'b0;
    logic [15:0]   ba_din = '0;

    int n_run  = 0;
    int n_fail = 0;

    // bank model state
    int            bst = 0;
    int            dly = 0;
    int            w   = 0;
    logic [AW-1:0] baddr = '0;
    logic          hold  = 1'b0;
    logic          stray = 1'b0;
    logic [AW-1:0] glog [$];

    always #5 clk = ~clk;

    jtframe_sdram64_rdcache #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .slot0_addr(a[0]), .slot1_addr(a[1]),
        .slot2_addr(a[2]), .slot3_addr(a[3]),
        .slot_cs(cs), .slot_ok(ok),
        .slot0_dout(dout[0]), .slot1_dout(dout[1]),
        .slot2_dout(dout[2]), .slot3_dout(dout[3]),
        .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_ack(ba_ack),
        .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
        .ba_din(ba_din)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SDRAM content: one fixed line for the directed test, a hash elsewhere
    function automatic logic [15:0] mem(input logic [AW-1:0] x);
        logic [15:0] t [4];
        t = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        if (x[AW-1:2] == 20'h41) return t[x[1:0]];
        return x[15:0] ^ {x[21:16], x[9:0]} ^ 16'h5a5a;
    endfunction

    function automatic logic [AW-1:0] gl(input int i);
        if (i < glog.size()) return glog[i];
        return '1;
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        logic [AW-1:0] x;
        x = 22'h104 + 22'(4 * $urandom_range(0, 5))
            + 22'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) x[21] = 1'b1;
        return x;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ok(input int n, input string tag);
        int k;
        k = 0;
        while (!ok[n] && k < 300) begin
            step();
            k++;
        end
        check(tag, ok[n], 1);
    endtask

    task automatic wait_bst(input int s, input string tag);
        int k;
        k = 0;
        while (bst != s && k < 100) begin
            step();
            k++;
        end
        check(tag, bst, s);
    endtask

    // Bank model: random ack and data delays, gaps between words
    always @(negedge clk) begin
        ba_ack = 1'b0;
        ba_dok = 1'b0;
        ba_dst = 1'b0;
        ba_rdy = 1'b0;
        ba_din = '0;
        if (rst) begin
            bst = 0;
        end else if (stray && bst == 0) begin
            ba_dok = 1'b1;
            ba_dst = 1'b1;
            ba_rdy = 1'b1;
            ba_din = 16'hdead;
        end else begin
            case (bst)
                0: if (ba_rd) begin
                    check("ba_align", 32'(ba_addr[1:0]), 0);
                    glog.push_back(ba_addr);
                    baddr = ba_addr;
                    dly   = $urandom_range(0, 2);
                    bst   = 1;
                end
                1: begin
                    check("req_stable", {ba_rd, ba_addr}, {1'b1, baddr});
                    if (!hold) begin
                        if (dly == 0) begin
                            ba_ack = 1'b1;
                            dly    = $urandom_range(0, 2);
                            w      = 0;
                            bst    = 2;
                        end else begin
                            dly--;
                        end
                    end
                end
                default: begin
                    check("data_no_rd", ba_rd, 0);
                    if (dly != 0) begin
                        dly--;
                    end else if ($urandom_range(0, 3) != 0) begin
                        ba_dok = 1'b1;
                        ba_dst = (w == 0);
                        ba_rdy = (w == 3);
                        ba_din = mem(baddr + 22'(w));
                        if (w == 3) bst = 0;
                        w++;
                    end
                end
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, g0, nrd, cnt2;
        int waitc [4];
        int maxw;
        logic [AW-1:0] olda;
        for (int n = 0; n < 4; n++) a[n] = '0;
        repeat (3) step();
        check("rst_ok", ok, 0);
        check("rst_rd", ba_rd, 0);
        check("rst_addr", ba_addr, 0);
        for (int n = 0; n < 4; n++) check("rst_dout", dout[n], 0);
        rst = 1'b0;
        step();

        // cold miss on slot 0
        a[0] = 22'h000105;
        cs   = 4'b0001;
        step();
        check("miss_rd", ba_rd, 1);
        k = 0;
        while (!ba_rdy && k < 100) begin
            step();
            k++;
        end
        check("cold_rdy", ba_rdy, 1);
        check("cold_gaddr", gl(0), 22'h000104);
        step();
        check("cold_ok_e", ok[0], 0);
        step();
        check("cold_ok_e1", ok[0], 1);
        check("cold_dout", dout[0], 16'h2222);

        // hit within the line
        a[0] = 22'h000107;
        step();
        check("hit_ok", ok[0], 1);
        check("hit_dout", dout[0], 16'h4444);
        nrd = 0;
        repeat (5) begin
            step();
            if (ba_rd) nrd++;
        end
        check("hit_no_rd", nrd, 0);
        check("hit_grants", glog.size(), 1);

        // round robin after reset
        rst = 1'b1;
        cs  = '0;
        step();
        rst = 1'b0;
        glog.delete();
        a[0] = 22'h010001;
        a[1] = 22'h020002;
        a[2] = 22'h030003;
        a[3] = 22'h040001;
        cs   = 4'hf;
        k = 0;
        while (ok != 4'hf && k < 400) begin
            step();
            k++;
        end
        check("rr_all_ok", ok, 4'hf);
        check("rr_grants", glog.size(), 4);
        for (int n = 0; n < 4; n++) begin
            check("rr_order", gl(n), {a[n][AW-1:2], 2'b00});
            check("rr_dout", dout[n], mem(a[n]));
        end

        // slot 2 abandons its fetch mid-burst
        cs   = '0;
        a[2] = 22'h003209;
        cs   = 4'b0100;
        g0   = glog.size();
        wait_bst(2, "ab_data");
        cs = '0;
        wait_bst(0, "ab_done");
        repeat (3) step();
        cs = 4'b0100;
        step();
        check("ab_ok", ok[2], 1);
        check("ab_dout", dout[2], mem(a[2]));
        check("ab_grants", glog.size(), g0 + 1);

        // clr while slot 1's burst is in flight
        a[0] = 22'h010001;
        a[1] = 22'h002345;
        cs   = 4'b0011;
        g0   = glog.size();
        wait_bst(2, "clr_data");
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_ok", ok, 0);
        k = 0;
        while (!ba_rdy && k < 100) begin
            step();
            k++;
        end
        check("clr_rdy", ba_rdy, 1);
        step();
        step();
        check("clr_no_ok", ok[1], 0);
        wait_ok(1, "clr_refetch_ok");
        check("clr_dout", dout[1], mem(a[1]));
        cnt2 = 0;
        for (int i = g0; i < glog.size(); i++)
            if (glog[i] == 22'h002344) cnt2++;
        check("clr_two_rd", cnt2, 2);
        wait_ok(0, "clr_s0_ok");

        // async reset while a request waits for ack
        a[3] = 22'h00abc7;
        hold = 1'b1;
        cs   = 4'b1001;
        k = 0;
        while (!(ba_rd && ok[0]) && k < 100) begin
            step();
            k++;
        end
        check("ar_req", {ba_rd, ok[0]}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check("ar_rd", ba_rd, 0);
        check("ar_ok", ok, 0);
        cs = '0;
        step();
        hold  = 1'b0;
        rst   = 1'b0;
        stray = 1'b1;
        nrd   = 0;
        repeat (2) begin
            step();
            if (ba_rd) nrd++;
        end
        stray = 1'b0;
        step();
        check("ar_stray_rd", nrd, 0);
        check("ar_stray_ok", ok, 0);
        glog.delete();
        a[0] = 22'h000555;
        cs   = 4'b1001;
        k = 0;
        while (glog.size() == 0 && k < 50) begin
            step();
            k++;
        end
        check("ar_first", gl(0), {a[0][AW-1:2], 2'b00});
        k = 0;
        while (ok != 4'b1001 && k < 300) begin
            step();
            k++;
        end
        check("ar_both_ok", ok, 4'b1001);

        // randomized traffic checked against memory content
        for (int n = 0; n < 4; n++) waitc[n] = 0;
        maxw = 0;
        repeat (3000) begin
            for (int n = 0; n < 4; n++) begin
                if (ok[n]) begin
                    check("rnd_dout", dout[n], mem(a[n]));
                    check("rnd_okcs", {cs[n], clr}, 2'b10);
                end
                if (cs[n] && !ok[n]) waitc[n]++;
                else waitc[n] = 0;
                if (waitc[n] > maxw) maxw = waitc[n];
            end
            clr = ($urandom_range(0, 199) == 0);
            for (int n = 0; n < 4; n++) begin
                if (clr) waitc[n] = 0;
                if (!cs[n] || ok[n] || $urandom_range(0, 31) == 0) begin
                    cs[n] = 1'($urandom_range(0, 1));
                    olda  = a[n];
                    if ($urandom_range(0, 1) == 1) a[n] = pick_addr();
                    if (a[n] != olda) waitc[n] = 0;
                end
            end
            step();
        end
        check("rnd_latency", 32'(maxw <= 150), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
